muladder_sequencer: RTL
=======================

# muladder_sequencer

Initiator/sink for the `MulAdder` DSP primitive (signed P = C ± A·B, fixed pipeline latency). It accepts a start command, then a handshaked stream of (weight, activation) pairs, and issues them back-to-back into `MulAdder`. It tracks in-flight products and accumulates the returned P values into one dot-product result. The result is presented on a valid/ready output, so convolution/FC control logic never handles DSP latency directly.

## Interface
- `DATA_W`, 16, width of A/B operands (signed)
- `P_W`, 36, width of C, P and the accumulator (signed)
- `LEN_W`, 8, width of the term-count field
- `MUL_LAT`, 3, `MulAdder` latency in CE-high cycles, ≥1
- `system_clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  command pulse; sampled only in IDLE
- `len`  in  LEN_W  number of product terms (0 allowed)
- `bias`  in  P_W  signed bias, captured at start
- `sub_mode`  in  1  captured at start; 1 selects P = C − A·B
- `in_valid`/`in_ready`  in/out  1  operand stream handshake
- `in_w`, `in_x`  in  DATA_W  signed weight / activation
- `out_valid`/`out_ready`  out/in  1  result handshake
- `out_data`  out  P_W  accumulated result
- `busy`  out  1  high in any state other than IDLE
- `ma_ce`, `ma_sclr`, `ma_subtract`  out  1  to `MulAdder` CE/SCLR/SUBTRACT
- `ma_a`, `ma_b`  out  DATA_W  to `MulAdder` A/B
- `ma_c`  out  P_W  to `MulAdder` C
- `ma_p`  in  P_W  from `MulAdder` P

## Operation
- States: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE, `start` = 1:
  - Capture `len`, `bias` and `sub_mode`.
  - Clear the accumulator, the issue counter and the tag pipe.
  - Assert `ma_sclr` for exactly that one cycle.
  - Go to RUN, or go to DONE with acc = `bias` if `len` = 0.
- `start` is ignored outside IDLE.
- RUN:
  - `in_ready` = 1; a term issues on each `in_valid && in_ready` cycle.
  - On an issue cycle: `ma_a` = `in_w`, `ma_b` = `in_x`; `ma_c` = bias for the first term, 0 for later terms; tag = 1.
  - On a non-issue cycle: `ma_a` = `ma_b` = `ma_c` = 0 and tag = 0 (bubble).
  - The issue that completes `len` terms moves the state to DRAIN.
- `ma_ce` = 1 in RUN and DRAIN, 0 otherwise. The DSP pipeline never stalls; bubbles carry tag 0.
- Tag pipe: MUL_LAT-deep shift of issue tags, shifting whenever `ma_ce` = 1. When the output tag is 1, acc ← acc + `ma_p`.
- Arithmetic is two's-complement wrap at P_W, with no saturation. With `sub_mode`, the result is bias − Σ w·x.
- DRAIN: `in_ready` = 0. Go to DONE when the tag pipe is empty and the last accumulate has been taken.
- DONE: `out_valid` = 1 and `out_data` = acc, held stable until `out_ready`. The handshake cycle returns the state to IDLE.
- `ma_subtract` = captured `sub_mode` while busy, 0 in IDLE.

## Timing
- Reset: state IDLE. All outputs are 0: `in_ready`, `out_valid`, `out_data`, `busy`, all `ma_*` outputs. Acc, counter and tags are cleared.
- Reset mid-operation aborts the command. No `out_valid` follows, and partial sums are discarded.
- Issue → return: a term issued at edge t has its P sampled at edge t+MUL_LAT.
- With `start` at cycle 0 and `in_valid` held high:
  - terms issue in cycles 1..len;
  - the last accumulate happens at the end of cycle len+MUL_LAT;
  - `out_valid` rises in cycle len+MUL_LAT+1.
- `len` = 0: `out_valid` in cycle 1 with `out_data` = `bias`. No `ma_ce` pulse is issued.
- `in_valid` gaps insert bubbles and extend latency by exactly the gap length.
- `out_ready` held low: stay in DONE indefinitely; `out_data` does not change.
- `out_ready` high on the first DONE cycle: single-cycle DONE. A `start` in the following IDLE cycle is accepted.
- Maximum `len` = 2^LEN_W − 1. The counter must not wrap.

## Structure
- State encodings, `DATA_W`/`P_W` defaults and `MUL_LAT` live in the shared `parameters.v`.
- One sub-module, `valid_delay_line`:
  - a MUL_LAT-deep, 1-bit shift register;
  - ports: enable, async clear, synchronous clear;
  - reusable for other fixed-latency DSP wrappers.
- `MulAdder` is instantiated by the parent, not inside this block.

## Test plan
- Wrap a `MulAdder` model with MUL_LAT = 3:
  - `len` = 4, `bias` = 100, pairs (−10,−5), (3,4), (−2,7), (1,1) streamed continuously.
  - Expect `out_data` = 149 and `out_valid` in cycle 8.
- `sub_mode` = 1, `len` = 2, `bias` = −20, pairs (−10,−5), (2,3). Expect `out_data` = −76.
- Same as the first test but `in_valid` low for 3 cycles after term 2.
  - Expect the same sum, `out_valid` 3 cycles later, and `ma_ce` continuous.
- `len` = 0, `bias` = −7. Expect `out_valid` in cycle 1, `out_data` = −7, and no `ma_ce` pulse.
- `out_ready` held low 5 cycles in DONE, with a `start` asserted during DONE.
  - Expect a stable `out_data` and the `start` ignored.
  - A `start` after the handshake is accepted.
- `rst_n` asserted during DRAIN.
  - Expect all outputs 0 and IDLE.
  - A fresh `len` = 1 command (4,5), `bias` 0, yields 20.

Source files
------------

// File: rtl/muladder_sequencer_pkg.sv
// muladder_sequencer shared definitions
// State encoding and default widths/latency for the DSP sequencer.
package muladder_sequencer_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int P_W_DEF     = 36;
    localparam int LEN_W_DEF   = 8;
    localparam int MUL_LAT_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    function automatic logic is_busy(seq_state_t s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/muladder_sequencer_if.sv
// muladder_sequencer command / operand / result bundle
// master = controller side, slave = sequencer side.
interface muladder_sequencer_if
    import muladder_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int P_W    = P_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
);

    logic              start;
    logic [LEN_W-1:0]  len;
    logic [P_W-1:0]    bias;
    logic              sub_mode;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_w;
    logic [DATA_W-1:0] in_x;

    logic              out_valid;
    logic              out_ready;
    logic [P_W-1:0]    out_data;

    modport master (
        output start, len, bias, sub_mode,
        output in_valid, in_w, in_x,
        output out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  start, len, bias, sub_mode,
        input  in_valid, in_w, in_x,
        input  out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/muladder_sequencer_valid_delay_line.sv
// valid_delay_line: DEPTH-deep 1-bit shift register
// Tracks which slots of a fixed-latency pipeline carry real data.
module valid_delay_line
    import muladder_sequencer_pkg::*;
#(
    parameter int DEPTH = MUL_LAT_DEF
) (
    input  logic clk,
    input  logic aclr_n,
    input  logic en,
    input  logic sclr,
    input  logic din,
    output logic dout,
    output logic pending
);

    logic [DEPTH-1:0] sr;

    // New tag enters at the top bit and walks down to bit 0.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            sr <= '0;
        end else if (sclr) begin
            sr <= '0;
        end else if (en) begin
            sr <= (sr >> 1) | (DEPTH'(din) << (DEPTH - 1));
        end
    end

    assign dout    = sr[0];
    // Tags still in flight behind the one at the output.
    assign pending = |(sr >> 1);

endmodule

// File: rtl/muladder_sequencer.sv
// muladder_sequencer: feeds a MulAdder and accumulates a dot product
// Hides the DSP latency behind a start command and a valid/ready result.
module muladder_sequencer
    import muladder_sequencer_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int P_W     = P_W_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic              system_clk,
    input  logic              rst_n,
    muladder_sequencer_if.slave bus,
    output logic              busy,
    output logic              ma_ce,
    output logic              ma_sclr,
    output logic              ma_subtract,
    output logic [DATA_W-1:0] ma_a,
    output logic [DATA_W-1:0] ma_b,
    output logic [P_W-1:0]    ma_c,
    input  logic [P_W-1:0]    ma_p
);

    seq_state_t       state;
    seq_state_t       state_nxt;

    logic [LEN_W-1:0] len_q;
    logic [P_W-1:0]   bias_q;
    logic             sub_q;
    logic [LEN_W-1:0] cnt;
    logic [P_W-1:0]   acc;

    logic             issue;
    logic             first_term;
    logic             last_term;
    logic             tag_out;
    logic             tag_pend;

    assign issue      = (state == ST_RUN) && bus.in_valid;
    assign first_term = (cnt == '0);
    // cnt stays below len_q in RUN, so this never wraps.
    assign last_term  = (cnt == len_q - LEN_W'(1));

    // State register.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.len == '0) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (issue && last_term) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!tag_pend) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode; non-issue cycles send zero bubbles.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        busy          = is_busy(state);
        ma_ce         = 1'b0;
        ma_sclr       = 1'b0;
        ma_subtract   = 1'b0;
        ma_a          = '0;
        ma_b          = '0;
        ma_c          = '0;
        unique case (state)
            ST_IDLE: begin
                ma_sclr = bus.start;
            end
            ST_RUN: begin
                bus.in_ready = 1'b1;
                ma_ce        = 1'b1;
                ma_subtract  = sub_q;
                if (issue) begin
                    ma_a = bus.in_w;
                    ma_b = bus.in_x;
                    if (first_term) begin
                        ma_c = bias_q;
                    end
                end
            end
            ST_DRAIN: begin
                ma_ce       = 1'b1;
                ma_subtract = sub_q;
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                bus.out_data  = acc;
                ma_subtract   = sub_q;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Command capture on an accepted start.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q  <= '0;
            bias_q <= '0;
            sub_q  <= 1'b0;
        end else if (ma_sclr) begin
            len_q  <= bus.len;
            bias_q <= bus.bias;
            sub_q  <= bus.sub_mode;
        end
    end

    // Issue counter.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ma_sclr) begin
            cnt <= '0;
        end else if (issue) begin
            cnt <= cnt + LEN_W'(1);
        end
    end

    // Accumulator; bias arrives via C of the first term, or directly for len 0.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (ma_sclr) begin
            acc <= (bus.len == '0) ? bus.bias : '0;
        end else if (ma_ce && tag_out) begin
            acc <= acc + ma_p;
        end
    end

    valid_delay_line #(
        .DEPTH (MUL_LAT)
    ) u_tags (
        .clk     (system_clk),
        .aclr_n  (rst_n),
        .en      (ma_ce),
        .sclr    (ma_sclr),
        .din     (issue),
        .dout    (tag_out),
        .pending (tag_pend)
    );

endmodule
